plot_fb_writer: RTL
===================

PLOT_FB_WRITER -- requirements
Module: plot_fb_writer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_x  input  8  pixel column from drawing stage.
REQ-005 in_y  input  7  pixel row from drawing stage.
REQ-006 in_colour  input  3  pixel colour.
REQ-007 in_plot  input  1  pixel valid this cycle.
REQ-008 in_ready  output  1  push will be accepted this cycle.
REQ-009 fb_grant  input  1  framebuffer port free this cycle; scanout owns it when low.
REQ-010 fb_we  output  1  framebuffer write strobe.
REQ-011 fb_addr  output  15  framebuffer word address.
REQ-012 fb_wdata  output  3  framebuffer write colour.
REQ-013 empty  output  1  FIFO holds no pixels.
REQ-014 overflow  output  1  sticky: at least one in-range pixel dropped.
REQ-015 clr_overflow  input  1  clears overflow and drop_count.
REQ-016 drop_count  output  8  dropped in-range pixels, saturating at 255.

Function
REQ-017 Clip: pixel with in_x >= 160 or in_y >= 120 is discarded silently; it does not enqueue, does not set overflow, does not count.
REQ-018 Address computed at enqueue: addr = in_y*160 + in_x = (in_y<<7)+(in_y<<5)+in_x, 15-bit unsigned, max 19199; stored with colour (18-bit entry).
REQ-019 Push: in_plot=1, in range, in_ready=1 at rising edge -> entry written at tail.
REQ-020 Pop: fb_we = !empty && fb_grant, combinational; fb_addr/fb_wdata = head entry; head advances on that edge.
REQ-021 fb_addr/fb_wdata hold head entry whenever !empty; 0 when empty.
REQ-022 in_ready = !full || fb_grant; push into full FIFO is legal only with simultaneous pop.
REQ-023 Latency: pixel pushed at edge N appears on fb_we in cycle after edge N at earliest; no bypass when empty.
REQ-024 Order: writes leave in exact push order; no coalescing of same-address pixels.
REQ-025 Drop: in_plot=1, in range, in_ready=0 -> pixel discarded, overflow<=1, drop_count increments (saturate 255).
REQ-026 clr_overflow=1 -> overflow<=0, drop_count<=0 next edge; a drop in the same cycle takes priority (overflow=1, drop_count=1).
REQ-027 Simultaneous push and pop at occupancy k -> occupancy stays k; pointers wrap modulo DEPTH.
REQ-028 empty and full derived from an occupancy counter (0..DEPTH), no pointer-equality ambiguity.
REQ-029 fb_grant low indefinitely -> FIFO fills to DEPTH, then further pixels drop per REQ-025; no deadlock when grant returns.

Reset
REQ-030 rst_n=0 at edge: occupancy 0, pointers 0, overflow 0, drop_count 0; any stored pixels discarded.
REQ-031 During/after reset cycle: empty=1, fb_we=0, fb_addr=0, fb_wdata=0, in_ready=1.
REQ-032 Reset mid-drain: no fb_we in the cycle following reset assertion edge regardless of fb_grant.

Structure
REQ-033 lab_pkg holds SCREEN_W=160, SCREEN_H=120, FB_ADDR_W=15 and a packed struct fb_pixel_t {addr[14:0], colour[2:0]}.
REQ-034 One sub-module: plot_fifo (synchronous FIFO, DEPTH param, fb_pixel_t entries, push/pop/full/empty/count); clip, address calc, drop accounting stay in plot_fb_writer.
REQ-035 Storage is plain registers or inferred RAM with registered write, combinational read of head.

Verification
REQ-036 Grant=1, push (x=5,y=3,c=4) -> next cycle fb_we=1, fb_addr=485, fb_wdata=4; empty=1 after.
REQ-037 Push (159,119,7) and (160,0,1) and (0,120,2) -> only one write, fb_addr=19199; overflow=0.
REQ-038 Grant=0, push 20 in-range pixels with DEPTH=16 -> in_ready=0 after 16, overflow=1, drop_count=4; grant=1 -> 16 writes in push order.
REQ-039 Full FIFO, grant=1, continuous pushes -> no drops, occupancy stays 16, one write per cycle.
REQ-040 Overflow set, clr_overflow=1 with no drop -> overflow=0, drop_count=0 next cycle; with concurrent drop -> overflow=1, drop_count=1.
REQ-041 8 entries queued, rst_n=0 one cycle -> empty=1, fb_we=0 thereafter with grant=1, in_ready=1.

Source files
------------

// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - screen geometry, framebuffer entry type and address helper
package lab_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [2:0]           colour;
  } fb_pixel_t;

  // Row-major word address: y*160 + x built from two shifts so no multiplier is needed
  function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
    return FB_ADDR_W'({y, 7'b0}) + FB_ADDR_W'({y, 5'b0}) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_fb_writer_if.sv
// rtl/plot_fb_writer_if.sv - pixel input and framebuffer write port bundle
interface plot_fb_writer_if;

  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        in_ready;
  logic        fb_grant;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;

  // Drawing stage / framebuffer arbiter side
  modport master (
    output in_x, in_y, in_colour, in_plot, fb_grant,
    input  in_ready, fb_we, fb_addr, fb_wdata
  );

  // Writer side
  modport slave (
    input  in_x, in_y, in_colour, in_plot, fb_grant,
    output in_ready, fb_we, fb_addr, fb_wdata
  );

endinterface

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - synchronous FIFO of framebuffer pixels with occupancy counter
module plot_fifo
  import lab_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  fb_pixel_t wr_data,
  output fb_pixel_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fb_pixel_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage write at the tail; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count disambiguates full/empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plot_fb_writer.sv
// rtl/plot_fb_writer.sv - clips pixels, queues them and drains into the framebuffer port
module plot_fb_writer
  import lab_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  plot_fb_writer_if.slave      bus,
  input  logic                 clr_overflow,
  output logic                 empty,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  logic      in_range;
  logic      full;
  logic      push;
  logic      drop;
  logic      pop;
  fb_pixel_t head;
  fb_pixel_t entry;

  assign in_range     = (bus.in_x < 8'(SCREEN_W)) && (bus.in_y < 7'(SCREEN_H));
  assign entry.addr   = pixel_addr(bus.in_x, bus.in_y);
  assign entry.colour = bus.in_colour;

  // A full FIFO still accepts when the scanout-free port pops the head this cycle
  assign bus.in_ready = !full || bus.fb_grant;
  assign push         = bus.in_plot && in_range && bus.in_ready;
  assign drop         = bus.in_plot && in_range && !bus.in_ready;

  // Gating on rst_n keeps a reset cycle from writing a stale head
  assign pop          = !empty && bus.fb_grant && rst_n;
  assign bus.fb_we    = pop;
  assign bus.fb_addr  = empty ? '0 : head.addr;
  assign bus.fb_wdata = empty ? '0 : head.colour;

  plot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Drop accounting: a drop wins over a clear in the same cycle and restarts the count at 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clr_overflow)             drop_count <= 8'd1;
      else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end
  end

endmodule
